if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports clk input 1 (system clock) and rst input 1 (reset); one clock; reset synchronous, active-low (asserted when rst==0), sampled on posedge clk.
REQ-002 SHALL have stall input StallBus (6) global stall vector; bit 0 governs this stage (Stop=1, NoStop=0).
REQ-003 SHALL have br_bus input BR_WD (33) {br_e, br_addr[31:0]} from decode stage.
REQ-004 SHALL have if_to_id_bus output IF_TO_ID_WD (33) {ce, pc[31:0]} to decode stage.
REQ-005 SHALL have inst_sram_en output 1, inst_sram_wen output 4, inst_sram_addr output 32, inst_sram_wdata output 32 (instruction SRAM request; data returns next cycle).
REQ-006 SHALL have parameter RESET_PC, default 32'hBFBF_FFFC, meaning the PC held in reset so that the first fetch is RESET_PC+4 (32'hBFC0_0000).

Function
REQ-007 SHALL hold state pc_reg[31:0], ce_reg, pend_v, pend_addr[31:0] and a 2-bit FSM: S_RESET, S_FETCH, S_HOLD, S_HOLD_BR.
REQ-008 SHALL compute next_pc = br_e ? br_addr : (pend_v ? pend_addr : pc_reg+4); addition modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-009 When stall[0]==NoStop, SHALL update pc_reg<=next_pc, ce_reg<=1, pend_v<=0.
REQ-010 When stall[0]==Stop, SHALL hold pc_reg and ce_reg unchanged.
REQ-011 When stall[0]==Stop and br_e==1, SHALL set pend_v<=1 and pend_addr<=br_addr; a later br_e during the same stall overwrites pend_addr (latest wins).
REQ-012 On the first NoStop cycle after a stall, SHALL redirect to br_addr if br_e==1 that cycle, else to pend_addr if pend_v, then clear pend_v.
REQ-013 FSM transitions: S_RESET->S_FETCH on first cycle with rst==1 and stall[0]==NoStop; S_FETCH->S_HOLD on Stop with br_e==0; S_FETCH/S_HOLD->S_HOLD_BR on Stop with br_e==1; S_HOLD/S_HOLD_BR->S_FETCH on NoStop; S_HOLD_BR stays on Stop.
REQ-014 In S_RESET with stall[0]==Stop, SHALL stay in S_RESET, ce_reg=0.
REQ-015 SHALL drive inst_sram_en=ce_reg of next-state (i.e. en = rst & ~stall[0] | ce_reg & stall[0]), inst_sram_addr=next_pc when stall[0]==NoStop else pc_reg; so SRAM sees the address being loaded into pc_reg.
REQ-016 SHALL drive inst_sram_wen=4'b0 and inst_sram_wdata=32'b0 always.
REQ-017 SHALL drive if_to_id_bus={ce_reg, pc_reg} directly from registers (no combinational path from br_bus).
REQ-018 SHALL pass br_addr unmodified; no alignment check in this block.

Reset
REQ-019 While rst==0: pc_reg=RESET_PC, ce_reg=0, pend_v=0, pend_addr=0, FSM=S_RESET; if_to_id_bus=33'h0_BFBF_FFFC.
REQ-020 Reset asserted mid-stall SHALL discard any pending redirect; asserted in the same cycle as br_e SHALL win over br_e.

Structure
REQ-021 StallBus, BR_WD, IF_TO_ID_WD, Stop/NoStop SHALL come from the shared defines header; FSM state encodings SHALL be local.
REQ-022 SHALL be a single module with no sub-modules; the pending-redirect register is inline.

Verification
REQ-023 Reset release, no stall: rst 0->1 -> inst_sram_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive cycles; ce 0 then 1.
REQ-024 Branch no stall: pc_reg=0xBFC00010, br_e=1, br_addr=0xBFC00100 -> next pc_reg 0xBFC00100, then 0xBFC00104.
REQ-025 Branch during stall: stall[0]=1 for 3 cycles, br_e=1 addr 0xBFC00200 in cycle 1 only -> pc held; after release pc_reg=0xBFC00200, pend_v=0.
REQ-026 Two branches during stall: 0xBFC00300 then 0xBFC00400 -> after release pc_reg=0xBFC00400; br_e=1 addr 0xBFC00500 on release cycle -> pc_reg=0xBFC00500.
REQ-027 Wrap: force pc_reg=0xFFFFFFFC, no stall -> next pc_reg 0x00000000.
REQ-028 Reset mid-stall with pending 0xBFC00600 -> after release pc sequence restarts at 0xBFC00000, 0xBFC00600 never fetched.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg -- shared definitions for the instruction-fetch stage.
//   Bus widths used between pipeline stages (stall vector, branch bus,
//   IF->ID bus), the Stop/NoStop stall encoding, and the sequential PC
//   increment helper.
package if_stage_pkg;

   localparam int StallBus    = 6;   // global stall vector, bit 0 = IF stage
   localparam int BR_WD       = 33;  // {br_e, br_addr[31:0]}
   localparam int IF_TO_ID_WD = 33;  // {ce, pc[31:0]}

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if -- bundle of the fetch stage's pipeline and SRAM signals.
//   stall           : global stall vector (bit 0 governs IF)
//   br_bus          : {br_e, br_addr} redirect request from decode
//   if_to_id_bus    : {ce, pc} handed to decode
//   inst_sram_en    : instruction SRAM read enable
//   inst_sram_wen   : instruction SRAM byte write enables (always 0)
//   inst_sram_addr  : instruction SRAM address (data returns next cycle)
//   inst_sram_wdata : instruction SRAM write data (always 0)
// Modport master is the fetch stage; slave is its surroundings.
interface if_stage_if;
   import if_stage_pkg::*;

   logic [StallBus-1:0]    stall;
   logic [BR_WD-1:0]       br_bus;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;

   modport master (
      input  stall,
      input  br_bus,
      output if_to_id_bus,
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   modport slave (
      output stall,
      output br_bus,
      input  if_to_id_bus,
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );

endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage.
//   Holds the PC, issues the instruction SRAM read for the address being
//   loaded into the PC, and remembers a branch redirect that arrives while
//   the stage is stalled so it is applied on the first unstalled cycle.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active low
//   bus : if_stage_if.master (stall, br_bus, if_to_id_bus, inst_sram_*)
// Parameter:
//   RESET_PC : PC value held in reset; first fetch is RESET_PC + 4.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  bus
);

   typedef enum logic [1:0] {
      S_RESET   = 2'd0,
      S_FETCH   = 2'd1,
      S_HOLD    = 2'd2,
      S_HOLD_BR = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] pc_reg;
   logic        ce_reg;
   logic        pend_v;
   logic [31:0] pend_addr;

   logic        stop_s;
   logic        br_e_s;
   logic [31:0] br_addr_s;
   logic [31:0] next_pc_s;
   logic        unused_stall_s;

   assign stop_s         = (bus.stall[0] == Stop);
   assign br_e_s         = bus.br_bus[32];
   assign br_addr_s      = bus.br_bus[31:0];
   assign unused_stall_s = ^bus.stall[StallBus-1:1];

   // Next PC: a live branch beats a remembered one, which beats sequential.
   always_comb begin
      next_pc_s = pc_incr(pc_reg);
      if (br_e_s) begin
         next_pc_s = br_addr_s;
      end else if (pend_v) begin
         next_pc_s = pend_addr;
      end else begin
         next_pc_s = pc_incr(pc_reg);
      end
   end

   // PC, fetch-valid, pending redirect and FSM state; reset wins over branch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= S_RESET;
         pc_reg    <= RESET_PC;
         ce_reg    <= 1'b0;
         pend_v    <= 1'b0;
         pend_addr <= 32'h0000_0000;
      end else begin
         if (!stop_s) begin
            pc_reg <= next_pc_s;
            ce_reg <= 1'b1;
            pend_v <= 1'b0;
         end else if (br_e_s) begin
            // Latest branch seen during a stall overwrites any earlier one.
            pend_v    <= 1'b1;
            pend_addr <= br_addr_s;
         end else begin
            pend_v    <= pend_v;
            pend_addr <= pend_addr;
         end

         case (state_r)
            S_RESET: begin
               if (!stop_s) state_r <= S_FETCH;
               else         state_r <= S_RESET;
            end
            S_FETCH: begin
               if (stop_s && br_e_s) state_r <= S_HOLD_BR;
               else if (stop_s)      state_r <= S_HOLD;
               else                  state_r <= S_FETCH;
            end
            S_HOLD: begin
               if (!stop_s)     state_r <= S_FETCH;
               else if (br_e_s) state_r <= S_HOLD_BR;
               else             state_r <= S_HOLD;
            end
            S_HOLD_BR: begin
               if (!stop_s) state_r <= S_FETCH;
               else         state_r <= S_HOLD_BR;
            end
            default: begin
               state_r <= S_RESET;
            end
         endcase
      end
   end

   // SRAM sees exactly the address (and valid) about to be loaded into pc/ce.
   always_comb begin
      bus.inst_sram_en   = (rst & ~bus.stall[0]) | (ce_reg & bus.stall[0]);
      bus.inst_sram_wen  = 4'b0000;
      bus.inst_sram_wdata = 32'h0000_0000;
      if (stop_s) begin
         bus.inst_sram_addr = pc_reg;
      end else begin
         bus.inst_sram_addr = next_pc_s;
      end
   end

   assign bus.if_to_id_bus = {ce_reg, pc_reg};

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed self-checking bench for if_stage.
module tb_if_stage;
   import if_stage_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   if_stage_if bus_if ();

   if_stage #(.RESET_PC(32'hBFBF_FFFC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic be, input logic [31:0] ba);
      bus_if.stall  = {5'b00000, st};
      bus_if.br_bus = {be, ba};
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      step();
      step();

      // Reset state
      check("rst_bus",   bus_if.if_to_id_bus, 33'h0_BFBF_FFFC);
      check("rst_pendv", {32'h0, dut.pend_v}, 33'h0);
      check("rst_en",    {32'h0, bus_if.inst_sram_en}, 33'h0);
      check("rst_wen",   {29'h0, bus_if.inst_sram_wen}, 33'h0);
      check("rst_wdata", {1'b0, bus_if.inst_sram_wdata}, 33'h0);

      // Reset release, no stall
      rst = 1'b1;
      #1;
      check("rel_addr0", {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0000);
      check("rel_en0",   {32'h0, bus_if.inst_sram_en}, 33'h1);
      step();
      check("rel_bus0",  bus_if.if_to_id_bus, 33'h1_BFC0_0000);
      check("rel_addr1", {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0004);
      step();
      check("rel_addr2", {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0008);
      step();
      step();
      step();
      check("seq_pc10",  bus_if.if_to_id_bus, 33'h1_BFC0_0010);

      // Branch, no stall
      drive(1'b0, 1'b1, 32'hBFC0_0100);
      check("br_addr",   {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0100);
      step();
      check("br_pc",     bus_if.if_to_id_bus, 33'h1_BFC0_0100);
      drive(1'b0, 1'b0, 32'h0);
      step();
      check("br_pc_seq", bus_if.if_to_id_bus, 33'h1_BFC0_0104);

      // Branch during a 3-cycle stall (cycle 1 only)
      drive(1'b1, 1'b1, 32'hBFC0_0200);
      check("stl_en",    {32'h0, bus_if.inst_sram_en}, 33'h1);
      check("stl_addr",  {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0104);
      step();
      drive(1'b1, 1'b0, 32'h0);
      step();
      step();
      check("stl_hold",  bus_if.if_to_id_bus, 33'h1_BFC0_0104);
      check("stl_pendv", {32'h0, dut.pend_v}, 33'h1);
      drive(1'b0, 1'b0, 32'h0);
      check("stl_rel_addr", {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0200);
      step();
      check("stl_rel_pc", bus_if.if_to_id_bus, 33'h1_BFC0_0200);
      check("stl_rel_pendv", {32'h0, dut.pend_v}, 33'h0);
      step();
      check("stl_seq",   bus_if.if_to_id_bus, 33'h1_BFC0_0204);

      // Two branches in one stall: latest wins
      drive(1'b1, 1'b1, 32'hBFC0_0300);
      step();
      drive(1'b1, 1'b1, 32'hBFC0_0400);
      step();
      drive(1'b1, 1'b0, 32'h0);
      step();
      check("two_hold",  bus_if.if_to_id_bus, 33'h1_BFC0_0204);
      drive(1'b0, 1'b0, 32'h0);
      step();
      check("two_pc",    bus_if.if_to_id_bus, 33'h1_BFC0_0400);

      // Live branch on release beats the pending one
      drive(1'b1, 1'b1, 32'hBFC0_0300);
      step();
      drive(1'b0, 1'b1, 32'hBFC0_0500);
      step();
      check("live_pc",   bus_if.if_to_id_bus, 33'h1_BFC0_0500);
      check("live_pendv", {32'h0, dut.pend_v}, 33'h0);

      // Wrap at the top of the address space
      drive(1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      check("wrap_top",  bus_if.if_to_id_bus, 33'h1_FFFF_FFFC);
      drive(1'b0, 1'b0, 32'h0);
      check("wrap_addr", {1'b0, bus_if.inst_sram_addr}, 33'h0_0000_0000);
      step();
      check("wrap_pc",   bus_if.if_to_id_bus, 33'h1_0000_0000);

      // Reset mid-stall discards the pending redirect
      drive(1'b1, 1'b1, 32'hBFC0_0600);
      step();
      drive(1'b1, 1'b0, 32'h0);
      check("rms_pendv", {32'h0, dut.pend_v}, 33'h1);
      rst = 1'b0;
      step();
      check("rms_bus",   bus_if.if_to_id_bus, 33'h0_BFBF_FFFC);
      check("rms_pendv0", {32'h0, dut.pend_v}, 33'h0);
      step();
      rst = 1'b1;
      #1;
      check("rms_en_stall", {32'h0, bus_if.inst_sram_en}, 33'h0);
      step();
      check("rms_hold",  bus_if.if_to_id_bus, 33'h0_BFBF_FFFC);
      drive(1'b0, 1'b0, 32'h0);
      check("rms_addr",  {1'b0, bus_if.inst_sram_addr}, 33'h0_BFC0_0000);
      step();
      check("rms_pc0",   bus_if.if_to_id_bus, 33'h1_BFC0_0000);
      step();
      check("rms_pc1",   bus_if.if_to_id_bus, 33'h1_BFC0_0004);

      // Reset in the same cycle as a branch: reset wins
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'hBFC0_0700);
      step();
      check("rbr_bus",   bus_if.if_to_id_bus, 33'h0_BFBF_FFFC);
      check("rbr_pendv", {32'h0, dut.pend_v}, 33'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
